// File: rtl/memory_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: memory windows, port ids,
// fault cause type and a window-membership helper.
package memory_bus_arbiter_pkg;

  localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TEXT_END   = 32'h0FFF_FFFF;
  localparam logic [31:0] DATA_BEGIN = 32'h8000_0000;
  localparam logic [31:0] DATA_END   = 32'h8FFF_FFFF;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_e;

  typedef enum logic {
    FAULT_NONE   = 1'b0,
    FAULT_ACCESS = 1'b1
  } fault_cause_e;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_decoder.sv
// Classifies a bus access against the TEXT/DATA windows and yields the
// legal bus enables plus a fault flag; usable by any bus master.
module mem_region_decoder
  import memory_bus_arbiter_pkg::*;
(
  input  logic [31:0]  address,
  input  logic         is_write,
  input  logic         is_fetch,
  output logic         read_en,
  output logic         write_en,
  output fault_cause_e fault
);

  logic text_hit_s;
  logic data_hit_s;

  // Window decode, fault detection and enable generation
  always_comb begin
    text_hit_s = in_window(address, TEXT_BEGIN, TEXT_END);
    data_hit_s = in_window(address, DATA_BEGIN, DATA_END);
    read_en    = 1'b0;
    write_en   = 1'b0;
    fault      = FAULT_NONE;
    if (!(text_hit_s || data_hit_s) || (is_write && text_hit_s) ||
        (is_fetch && (address[1:0] != 2'b00))) begin
      fault = FAULT_ACCESS;
    end else begin
      read_en  = !is_write;
      write_en = is_write;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch port and the
// load/store port, with one-cycle registered responses and stall counters.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_req,
  input  logic [31:0]                  i_address,
  output logic                         i_gnt,
  output logic                         i_rvalid,
  output logic [31:0]                  i_rdata,
  output logic                         i_err,
  input  logic                         d_req,
  input  logic [31:0]                  d_address,
  input  logic                         d_write_enable,
  input  logic [3:0]                   d_byte_enable,
  input  logic [31:0]                  d_write_data,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [31:0]                  d_rdata,
  output logic                         d_err,
  output logic [31:0]                  bus_address,
  output logic                         bus_read_enable,
  output logic                         bus_write_enable,
  output logic [3:0]                   bus_byte_enable,
  output logic [31:0]                  bus_write_data,
  input  logic [31:0]                  bus_read_data,
  output logic [STALL_COUNT_WIDTH-1:0] i_stall_count,
  output logic [STALL_COUNT_WIDTH-1:0] d_stall_count
);

  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_MAX = {STALL_COUNT_WIDTH{1'b1}};
  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_ONE =
    {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};

  port_id_e     last_grant_r;
  logic [31:0]  sel_address_s;
  logic         sel_write_s;
  logic [3:0]   sel_byte_enable_s;
  logic [31:0]  sel_write_data_s;
  logic         dec_read_en_s;
  logic         dec_write_en_s;
  fault_cause_e dec_fault_s;
  logic         fault_s;

  // Grant selection: lone requester wins, conflicts go to the port not served last
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end else if (i_req && d_req) begin
      if (last_grant_r == PORT_DATA) begin
        i_gnt = 1'b1;
      end else begin
        d_gnt = 1'b1;
      end
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end
  end

  // Winner payload mux; idle bus is driven to zero
  always_comb begin
    sel_address_s     = 32'h0000_0000;
    sel_write_s       = 1'b0;
    sel_byte_enable_s = 4'b0000;
    sel_write_data_s  = 32'h0000_0000;
    if (i_gnt) begin
      sel_address_s = i_address;
    end else if (d_gnt) begin
      sel_address_s     = d_address;
      sel_write_s       = d_write_enable;
      sel_byte_enable_s = d_byte_enable;
      sel_write_data_s  = d_write_data;
    end else begin
      sel_address_s = 32'h0000_0000;
    end
  end

  mem_region_decoder u_decoder (
    .address  (sel_address_s),
    .is_write (sel_write_s),
    .is_fetch (i_gnt),
    .read_en  (dec_read_en_s),
    .write_en (dec_write_en_s),
    .fault    (dec_fault_s)
  );

  assign fault_s          = (dec_fault_s == FAULT_ACCESS);
  assign bus_address      = sel_address_s;
  assign bus_read_enable  = (i_gnt || d_gnt) && dec_read_en_s;
  assign bus_write_enable = d_gnt && dec_write_en_s;
  assign bus_byte_enable  = sel_byte_enable_s;
  assign bus_write_data   = sel_write_data_s;

  // Round-robin history; holds through idle cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= PORT_DATA;
    end else if (i_gnt) begin
      last_grant_r <= PORT_FETCH;
    end else if (d_gnt) begin
      last_grant_r <= PORT_DATA;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // One-cycle responses; the losing port keeps its last data and error
  always_ff @(posedge clock) begin
    if (reset) begin
      i_rvalid <= 1'b0;
      i_rdata  <= 32'h0000_0000;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'h0000_0000;
      d_err    <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      if (i_gnt) begin
        i_rdata <= bus_read_enable ? bus_read_data : 32'h0000_0000;
        i_err   <= fault_s;
      end
      if (d_gnt) begin
        d_rdata <= bus_read_enable ? bus_read_data : 32'h0000_0000;
        d_err   <= fault_s;
      end
    end
  end

  // Saturating stall counters
  always_ff @(posedge clock) begin
    if (reset) begin
      i_stall_count <= {STALL_COUNT_WIDTH{1'b0}};
      d_stall_count <= {STALL_COUNT_WIDTH{1'b0}};
    end else begin
      if (i_req && !i_gnt && (i_stall_count != STALL_MAX)) begin
        i_stall_count <= i_stall_count + STALL_ONE;
      end
      if (d_req && !d_gnt && (d_stall_count != STALL_MAX)) begin
        d_stall_count <= d_stall_count + STALL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: a cycle model checked every negedge
// plus hand-computed literal checks on the main scenarios.
module tb_memory_bus_arbiter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_req, d_req, d_write_enable;
  logic [31:0]  i_address, d_address, d_write_data, bus_read_data;
  logic [3:0]   d_byte_enable;
  logic         i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
  logic [31:0]  i_rdata, d_rdata, bus_address, bus_write_data;
  logic         bus_read_enable, bus_write_enable;
  logic [3:0]   bus_byte_enable;
  logic [W-1:0] i_stall_count, d_stall_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  memory_bus_arbiter #(.STALL_COUNT_WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_address(i_address), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_address(d_address), .d_write_enable(d_write_enable),
    .d_byte_enable(d_byte_enable), .d_write_data(d_write_data), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .bus_address(bus_address), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_byte_enable(bus_byte_enable),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .i_stall_count(i_stall_count), .d_stall_count(d_stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state (values the registered outputs must hold now)
  bit          m_last_data = 1'b1;
  bit          m_i_rvalid = 1'b0, m_d_rvalid = 1'b0, m_i_err = 1'b0, m_d_err = 1'b0;
  logic [31:0] m_i_rdata = 32'h0, m_d_rdata = 32'h0;
  int          m_i_stall = 0, m_d_stall = 0;
  bit          n_last_data, n_i_rvalid, n_d_rvalid, n_i_err, n_d_err;
  logic [31:0] n_i_rdata, n_d_rdata;
  int          n_i_stall, n_d_stall;
  bit          pend_i = 1'b0, pend_d = 1'b0;
  logic [31:0] pend_i_addr, pend_d_addr;

  function automatic bit is_fault(input logic [31:0] a, input bit wr, input bit fetch);
    bit in_text, in_data;
    in_text = (a >= 32'h0040_0000) && (a <= 32'h0FFF_FFFF);
    in_data = (a >= 32'h8000_0000) && (a <= 32'h8FFF_FFFF);
    return (!in_text && !in_data) || (wr && in_text) || (fetch && (a % 4 != 0));
  endfunction

  // Model evaluation and per-cycle comparison, away from the active edge
  always @(negedge clock) begin
    bit          eg_i, eg_d, wr, flt, re, we;
    logic [31:0] addr;
    eg_i = 1'b0; eg_d = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
        eg_i = m_last_data;
        eg_d = !m_last_data;
      end else begin
        eg_i = i_req;
        eg_d = d_req;
      end
    end
    addr = eg_i ? i_address : (eg_d ? d_address : 32'h0);
    wr   = eg_d && d_write_enable;
    flt  = is_fault(addr, wr, eg_i);
    re   = (eg_i || eg_d) && !flt && !wr;
    we   = (eg_i || eg_d) && !flt && wr;

    if (chk_en) begin
      check("i_gnt", i_gnt, eg_i);
      check("d_gnt", d_gnt, eg_d);
      check("bus_address", bus_address, addr);
      check("bus_read_enable", bus_read_enable, re);
      check("bus_write_enable", bus_write_enable, we);
      if (!eg_i) begin
        check("bus_byte_enable", bus_byte_enable, eg_d ? d_byte_enable : 4'h0);
        check("bus_write_data", bus_write_data, eg_d ? d_write_data : 32'h0);
      end
      check("i_rvalid", i_rvalid, m_i_rvalid);
      check("i_rdata", i_rdata, m_i_rdata);
      check("i_err", i_err, m_i_err);
      check("d_rvalid", d_rvalid, m_d_rvalid);
      check("d_rdata", d_rdata, m_d_rdata);
      check("d_err", d_err, m_d_err);
      check("i_stall_count", i_stall_count, m_i_stall);
      check("d_stall_count", d_stall_count, m_d_stall);
      if (!reset && ((pend_i && (!i_req || i_address !== pend_i_addr)) ||
                     (pend_d && (!d_req || d_address !== pend_d_addr)))) begin
        errors++;
        $display("FAIL protocol request dropped or changed before grant at %0t", $time);
      end
    end

    if (reset) begin
      n_last_data = 1'b1;
      n_i_rvalid = 1'b0; n_i_rdata = 32'h0; n_i_err = 1'b0;
      n_d_rvalid = 1'b0; n_d_rdata = 32'h0; n_d_err = 1'b0;
      n_i_stall = 0; n_d_stall = 0;
    end else begin
      n_last_data = eg_d ? 1'b1 : (eg_i ? 1'b0 : m_last_data);
      n_i_rvalid = eg_i; n_i_rdata = m_i_rdata; n_i_err = m_i_err;
      n_d_rvalid = eg_d; n_d_rdata = m_d_rdata; n_d_err = m_d_err;
      if (eg_i) begin
        n_i_rdata = re ? bus_read_data : 32'h0;
        n_i_err   = flt;
      end
      if (eg_d) begin
        n_d_rdata = re ? bus_read_data : 32'h0;
        n_d_err   = flt;
      end
      n_i_stall = (i_req && !eg_i && m_i_stall < 15) ? m_i_stall + 1 : m_i_stall;
      n_d_stall = (d_req && !eg_d && m_d_stall < 15) ? m_d_stall + 1 : m_d_stall;
    end
  end

  // Model state advance and pending-request bookkeeping
  always @(posedge clock) begin
    m_last_data <= n_last_data;
    m_i_rvalid <= n_i_rvalid; m_i_rdata <= n_i_rdata; m_i_err <= n_i_err;
    m_d_rvalid <= n_d_rvalid; m_d_rdata <= n_d_rdata; m_d_err <= n_d_err;
    m_i_stall <= n_i_stall; m_d_stall <= n_d_stall;
    pend_i <= !reset && i_req && !i_gnt;
    pend_d <= !reset && d_req && !d_gnt;
    pend_i_addr <= i_address;
    pend_d_addr <= d_address;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write_enable = 1'b0;
    i_address = 32'h0; d_address = 32'h0; d_write_data = 32'h0;
    d_byte_enable = 4'h0; bus_read_data = 32'h0;
    step(1);
    chk_en = 1'b1;
    check("reset_i_rvalid", i_rvalid, 32'h0);
    check("reset_d_stall", d_stall_count, 32'h0);
    step(1);
    reset = 1'b0;

    // Single fetch
    i_req = 1'b1; i_address = 32'h0040_0000; bus_read_data = 32'h0000_0013;
    #1 check("t1_i_gnt", i_gnt, 32'h1);
    step(1);
    i_req = 1'b0;
    #1 check("t1_i_rvalid", i_rvalid, 32'h1);
    check("t1_i_rdata", i_rdata, 32'h0000_0013);
    check("t1_i_err", i_err, 32'h0);

    // Conflict alternation from a fresh reset: I, D, I, D
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    i_req = 1'b1; i_address = 32'h0040_0004;
    d_req = 1'b1; d_address = 32'h8000_0010; d_write_enable = 1'b0;
    d_byte_enable = 4'hF; bus_read_data = 32'h0000_1111;
    for (int k = 0; k < 4; k++) begin
      #1 check("t2_i_gnt_seq", i_gnt, (k % 2 == 0) ? 32'h1 : 32'h0);
      step(1);
    end
    d_req = 1'b0;
    #1 check("t2_i_stall", i_stall_count, 32'h2);
    check("t2_d_stall", d_stall_count, 32'h2);
    step(1);
    i_req = 1'b0;

    // Store
    d_req = 1'b1; d_write_enable = 1'b1; d_address = 32'h8000_0004;
    d_byte_enable = 4'b0011; d_write_data = 32'hDEAD_BEEF;
    #1 check("t3_bus_we", bus_write_enable, 32'h1);
    check("t3_bus_re", bus_read_enable, 32'h0);
    check("t3_bus_addr", bus_address, 32'h8000_0004);
    check("t3_bus_be", bus_byte_enable, 32'h3);
    check("t3_bus_wd", bus_write_data, 32'hDEAD_BEEF);
    step(1);
    d_req = 1'b0;
    #1 check("t3_d_rvalid", d_rvalid, 32'h1);
    check("t3_d_rdata", d_rdata, 32'h0);
    check("t3_d_err", d_err, 32'h0);

    // Faults: store to TEXT, load outside windows, misaligned fetch
    d_req = 1'b1; d_write_enable = 1'b1; d_address = 32'h0040_0000;
    #1 check("t4_store_text_gnt", d_gnt, 32'h1);
    check("t4_store_text_we", bus_write_enable, 32'h0);
    step(1);
    d_write_enable = 1'b0; d_address = 32'h0000_0000;
    #1 check("t4_store_text_err", {d_rvalid, d_err}, 32'h3);
    check("t4_load_zero_re", bus_read_enable, 32'h0);
    step(1);
    d_req = 1'b0; i_req = 1'b1; i_address = 32'h0040_0002;
    #1 check("t4_load_zero_err", {d_rvalid, d_err}, 32'h3);
    check("t4_fetch_mis_gnt", i_gnt, 32'h1);
    check("t4_fetch_mis_re", bus_read_enable, 32'h0);
    step(1);
    i_req = 1'b0;
    #1 check("t4_fetch_mis_err", {i_rvalid, i_err}, 32'h3);
    check("t4_fetch_mis_rdata", i_rdata, 32'h0);

    // Reset in the cycle the load would be granted
    d_req = 1'b1; d_write_enable = 1'b0; d_address = 32'h8000_0010;
    #1 check("t5_d_gnt", d_gnt, 32'h1);
    reset = 1'b1;
    #1 check("t5_d_gnt_in_reset", d_gnt, 32'h0);
    step(1);
    reset = 1'b0; i_req = 1'b1; i_address = 32'h0040_0000;
    #1 check("t5_d_rvalid", d_rvalid, 32'h0);
    check("t5_i_stall", i_stall_count, 32'h0);
    check("t5_d_stall", d_stall_count, 32'h0);
    check("t5_first_conflict_fetch", {i_gnt, d_gnt}, 32'h2);

    // Long conflict saturates both 4-bit counters
    step(40);
    check("t6_i_stall_sat", i_stall_count, 32'hF);
    check("t6_d_stall_sat", d_stall_count, 32'hF);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
Two-port arbiter that shares the single combined text/data memory bus between the core's instruction-fetch port (read-only) and its load/store port. Each cycle it selects at most one requester using round-robin on conflict. It drives the bus, classifies the address against the TEXT/DATA windows, and registers the bus read data into a one-cycle-later response on the winning port. Saturating stall counters per port support performance analysis.

Parameters:
STALL_COUNT_WIDTH, 16, width of each per-port saturating stall counter.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request; held with i_address stable until i_gnt
i_address  input  32  fetch byte address
i_gnt  output  1  fetch request accepted this cycle (combinational)
i_rvalid  output  1  fetch response valid (cycle after i_gnt)
i_rdata  output  32  fetch response data
i_err  output  1  fetch access fault, qualified by i_rvalid
d_req  input  1  load/store request; held with its payload stable until d_gnt
d_address  input  32  load/store byte address
d_write_enable  input  1  1 = store, 0 = load
d_byte_enable  input  4  store byte lanes
d_write_data  input  32  store data
d_gnt  output  1  load/store accepted this cycle (combinational)
d_rvalid  output  1  load/store response valid (cycle after d_gnt)
d_rdata  output  32  load data; 0 for stores
d_err  output  1  load/store access fault, qualified by d_rvalid
bus_address  output  32  to memory bus address
bus_read_enable  output  1  to memory bus read_enable
bus_write_enable  output  1  to memory bus write_enable
bus_byte_enable  output  4  to memory bus byte_enable
bus_write_data  output  32  to memory bus write_data
bus_read_data  input  32  from memory bus read_data (combinational, same cycle)
i_stall_count  output  STALL_COUNT_WIDTH  cycles with i_req && !i_gnt
d_stall_count  output  STALL_COUNT_WIDTH  cycles with d_req && !d_gnt

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, i_err=0, d_err=0, both stall counters=0. last_grant register = DATA, so fetch wins the first conflict.
- Arbitration (combinational):
  - Only one requester: that requester is granted.
  - Both requesting: grant the port not in last_grant.
  - last_grant updates at the clock edge to the port granted that cycle. It holds when no grant occurs.
  - Never more than one grant per cycle.
  - While reset=1, both gnt outputs are 0.
- Bus drive:
  - bus_address comes from the winner.
  - With no winner, all bus enables are 0 and bus_address/byte_enable/write_data are 0.
- Address classification of the winner:
  - TEXT hit: TEXT_BEGIN <= addr <= TEXT_END.
  - DATA hit: DATA_BEGIN <= addr <= DATA_END.
  - Fault conditions:
    - addr in neither window;
    - store to TEXT;
    - addr[1:0] != 0 on a fetch.
  - On a fault the request is still granted, but bus_read_enable and bus_write_enable are forced to 0.
- Enables for a legal access:
  - Fetch/load: bus_read_enable=1.
  - Store: bus_write_enable=1, bus_read_enable=0.
- Response timing: fixed latency of 1.
  - At the edge ending the grant cycle, the winner's rvalid goes to 1 for exactly one cycle.
  - rdata = bus_read_data sampled at that edge for a legal read; 0 for stores and faults.
  - err = fault flag.
  - The non-winning port's rvalid goes to 0. Its rdata and err hold.
- Back-to-back: a port may be granted every cycle. Its rvalid then stays high with new data each cycle.
- Stall counters:
  - Increment when req && !gnt.
  - Saturate at all-ones; no wrap-around.
  - Never decrement; cleared only by reset.
- Reset mid-operation: a response due on the next edge is dropped (rvalid=0), and the arbitration state returns to its reset value.
- Requesters must not drop req or change payload before gnt. Behaviour under such a protocol violation is undefined, and the bench asserts on it.

Decomposition:
- TEXT_BEGIN/TEXT_END/DATA_BEGIN/DATA_END come from the shared config package.
- Add to the shared constants package:
  - a port-id enum (PORT_FETCH, PORT_DATA);
  - a 1-bit fault-cause typedef.
- One natural sub-module, mem_region_decoder: combinational (address, is_write, is_fetch) -> (read_en, write_en, fault). Reusable by future bus masters.

Test Plan:
- Reset, then i_req=1 at 0x00400000 with bus_read_data=0x00000013 -> i_gnt=1 same cycle; next cycle i_rvalid=1, i_rdata=0x00000013, i_err=0.
- i_req and d_req (load at 0x80000010) held high 4 cycles -> grants alternate I,D,I,D; each port is stalled 2 cycles, so i_stall_count=2 and d_stall_count=2.
- Store d_address=0x80000004, byte_enable=4'b0011, data=0xDEADBEEF -> bus_write_enable=1 with matching payload; next cycle d_rvalid=1, d_rdata=0, d_err=0.
- Store to 0x00400000, then load at 0x00000000, then fetch at 0x00400002 -> each is granted with both bus enables 0; next cycle err=1 with rvalid.
- Reset asserted in the cycle d_gnt=1 -> next cycle d_rvalid=0 and counters=0; first conflict after reset grants fetch.
- Force d_req high with i_req held for 2^16+5 cycles (STALL_COUNT_WIDTH=16 shortcut via bench-forced priority or a parameter override of 4) -> counter stops at 0xF/0xFFFF and does not wrap.
